// File: rtl/pipe_pkg.sv
// Shared control-field encodings and per-boundary NOP constants for the RV64 pipeline.
// Stage registers use the *_NOP_CTRL constants as their bubble encoding (RST_CTRL).
package pipe_pkg;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_vala_sel_e;

  typedef enum logic [1:0] {
    ALU_B_RS2  = 2'd0,
    ALU_B_IMM  = 2'd1,
    ALU_B_FOUR = 2'd2
  } alu_valb_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_func_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_vald_sel_e;

  localparam logic REG_WEN_OFF = 1'b0;
  localparam logic REG_WEN_ON  = 1'b1;

  // ID/EX: alu a/b/func, mem ren/wen/wmask, wb wen/rd/sel, jump, jalr
  localparam int ID_EX_CTRL_W  = 2 + 2 + 4 + 1 + 1 + 8 + 1 + 5 + 2 + 1 + 1;
  // EX/MEM: mem ren/wen/wmask, wb wen/rd/sel
  localparam int EX_MEM_CTRL_W = 1 + 1 + 8 + 1 + 5 + 2;
  // MEM/WB: wb wen/rd/sel
  localparam int MEM_WB_CTRL_W = 1 + 5 + 2;

  // A bubble must never write memory or the register file.
  localparam logic [ID_EX_CTRL_W-1:0] ID_EX_NOP_CTRL = {
    ALU_A_RS1, ALU_B_IMM, ALU_ADD, 1'b0, 1'b0, 8'h00,
    REG_WEN_OFF, 5'd0, WB_ALU, 1'b0, 1'b0
  };
  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_NOP_CTRL = {
    1'b0, 1'b0, 8'h00, REG_WEN_OFF, 5'd0, WB_ALU
  };
  localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_NOP_CTRL = {
    REG_WEN_OFF, 5'd0, WB_ALU
  };

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry FIFO stage register (main + skid) with a registered in_ready_o, so no
// combinational path exists from out_ready_i to in_ready_o.
module pipe_skid_buf #(
  parameter int                DATA_W   = 256,
  parameter int                CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] RST_CTRL = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic              main_valid_d, main_valid_q;
  logic [CTRL_W-1:0] main_ctrl_d, main_ctrl_q;
  logic [DATA_W-1:0] main_data_d, main_data_q;
  logic              skid_valid_d, skid_valid_q;
  logic [CTRL_W-1:0] skid_ctrl_d, skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_d, skid_data_q;
  logic              acc, ret;

  assign in_ready_o  = !skid_valid_q;
  assign acc         = in_valid_i && !skid_valid_q;
  assign ret         = main_valid_q && out_ready_i;
  assign out_valid_o = main_valid_q;
  assign out_ctrl_o  = main_ctrl_q;
  assign out_data_o  = main_data_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = RST_CTRL;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Full: nothing is accepted; a retire promotes the skid entry.
      if (ret) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (acc) begin
      if (!main_valid_q || ret) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl_i;
        main_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl_i;
        skid_data_d  = in_data_i;
      end
    end else if (ret) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = RST_CTRL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= RST_CTRL;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= RST_CTRL;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with bubble-safe control and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN for the two-entry skid variant.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 256,
  parameter int                CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] RST_CTRL = {CTRL_W{1'b0}},
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef PIPE_STAGE_SKID_EN
  pipe_skid_buf #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RST_CTRL (RST_CTRL)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ctrl_i   (in_ctrl_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ctrl_o  (out_ctrl_o),
    .out_data_o  (out_data_o)
  );
`else
  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              acc, ret;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign acc         = in_valid_i && in_ready_o;
  assign ret         = valid_q && out_ready_i;
  assign out_valid_o = valid_q;
  assign out_ctrl_o  = ctrl_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = RST_CTRL;
    end else if (acc) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl_i;
      data_d  = in_data_i;
    end else if (ret) begin
      valid_d = 1'b0;
      ctrl_d  = RST_CTRL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= RST_CTRL;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end
`endif

  // Stall counter: counts cycles the downstream refuses a presented entry.
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios with literal expectations,
// then randomized traffic checked against a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int             DW  = 16;
  localparam int             CW  = 8;
  localparam int             NW  = 4;
  localparam logic [CW-1:0]  NOP = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [CW-1:0] in_ctrl_i = '0;
  logic [DW-1:0] in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [CW-1:0] out_ctrl_o;
  logic [DW-1:0] out_data_o;
  logic [NW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .RST_CTRL (NOP),
    .CNT_W    (NW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ctrl_i   (in_ctrl_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ctrl_o  (out_ctrl_o),
    .out_data_o  (out_data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: FIFO of held entries (front = presented downstream).
  logic [DW-1:0] q_data[$];
  logic [CW-1:0] q_ctrl[$];
  logic [DW-1:0] m_last = '0;
  logic [NW-1:0] m_cnt = '0;

  function automatic bit m_ready();
`ifdef PIPE_STAGE_SKID_EN
    return q_data.size() < 2;
`else
    return (q_data.size() == 0) || out_ready_i;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit nonempty;
    nonempty = q_data.size() > 0;
    check("valid", 32'(out_valid_o), 32'(nonempty));
    check("ctrl", 32'(out_ctrl_o), nonempty ? 32'(q_ctrl[0]) : 32'(NOP));
    check("data", 32'(out_data_o), nonempty ? 32'(q_data[0]) : 32'(m_last));
    check("in_ready", 32'(in_ready_o), 32'(m_ready()));
    check("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
  endtask

  task automatic model_step();
    bit acc, ret;
    if (rst) begin
      q_data.delete();
      q_ctrl.delete();
      m_last = '0;
      m_cnt  = '0;
    end else begin
      acc = in_valid_i && m_ready();
      ret = (q_data.size() > 0) && out_ready_i;
      if (q_data.size() > 0 && !out_ready_i && m_cnt != '1) m_cnt++;
      if (flush_i) begin
        q_data.delete();
        q_ctrl.delete();
      end else begin
        if (ret) begin
          void'(q_data.pop_front());
          void'(q_ctrl.pop_front());
        end
        if (acc) begin
          q_data.push_back(in_data_i);
          q_ctrl.push_back(in_ctrl_i);
        end
      end
      if (q_data.size() > 0) m_last = q_data[0];
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic r, input logic f, input logic v,
                       input logic [CW-1:0] c, input logic [DW-1:0] d, input logic o);
    rst = r; flush_i = f; in_valid_i = v; in_ctrl_i = c; in_data_i = d; out_ready_i = o;
    #1;
    if (chk_en) model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b1, 8'h33, 16'h1111, 1'b1);
    chk_en = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 8'h33, 16'h1111, 1'b1);
    check("rst_valid", 32'(out_valid_o), 32'h0);
    check("rst_ctrl", 32'(out_ctrl_o), 32'hA5);
    check("rst_data", 32'(out_data_o), 32'h0);
    check("rst_cnt", 32'(stall_cnt_o), 32'h0);
    check("rst_ready", 32'(in_ready_o), 32'h1);

    // Streaming 1, 2, 3 with downstream always ready.
    cycle(1'b0, 1'b0, 1'b1, 8'h11, 16'h0001, 1'b1);
    check("first_valid", 32'(out_valid_o), 32'h1);
    check("stream1", 32'(out_data_o), 32'h1);
    check("stream1_ctrl", 32'(out_ctrl_o), 32'h11);
    cycle(1'b0, 1'b0, 1'b1, 8'h12, 16'h0002, 1'b1);
    check("stream2", 32'(out_data_o), 32'h2);
    cycle(1'b0, 1'b0, 1'b1, 8'h13, 16'h0003, 1'b1);
    check("stream3", 32'(out_data_o), 32'h3);
    check("stream_cnt", 32'(stall_cnt_o), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    check("drain_valid", 32'(out_valid_o), 32'h0);
    check("drain_ctrl", 32'(out_ctrl_o), 32'hA5);
    check("drain_data", 32'(out_data_o), 32'h3);

    // Five stalled cycles; a second entry is offered on the first of them.
    cycle(1'b0, 1'b0, 1'b1, 8'h40, 16'h0040, 1'b0);
    for (int k = 0; k < 5; k++)
      cycle(1'b0, 1'b0, (k == 0), 8'h41, 16'h0041, 1'b0);
    check("stall_cnt5", 32'(stall_cnt_o), 32'h5);
    check("stall_hold", 32'(out_data_o), 32'h40);
    check("stall_valid", 32'(out_valid_o), 32'h1);
    check("stall_ready", 32'(in_ready_o), 32'h0);

    // Flush while stalled, then flush while an input is accepted.
    cycle(1'b0, 1'b1, 1'b1, 8'h77, 16'hDEAD, 1'b0);
    check("flush_valid", 32'(out_valid_o), 32'h0);
    check("flush_ctrl", 32'(out_ctrl_o), 32'hA5);
    check("flush_ready", 32'(in_ready_o), 32'h1);
    check("flush_cnt", 32'(stall_cnt_o), 32'h6);
    cycle(1'b0, 1'b1, 1'b1, 8'h78, 16'hBEEF, 1'b1);
    check("flush_acc_valid", 32'(out_valid_o), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    check("flush_gone", 32'(out_valid_o), 32'h0);
    check("flush_data_hold", 32'(out_data_o), 32'h40);

    // Saturation of the 4-bit counter, then reset clears it.
    cycle(1'b0, 1'b0, 1'b1, 8'h50, 16'h0050, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    check("sat_cnt", 32'(stall_cnt_o), 32'hF);
    check("sat_data", 32'(out_data_o), 32'h50);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    check("rst_cnt_clr", 32'(stall_cnt_o), 32'h0);
    check("rst_valid_clr", 32'(out_valid_o), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 7),
            CW'($urandom),
            DW'($urandom),
            ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
